// File: rtl/serial_pkt_ctrl.sv
// Serial packet framer: hunts for a header byte in a bit stream, then emits one
// FIFO write per payload byte with done/type/overflow reporting.
module serial_pkt_ctrl #(
  parameter int unsigned PAYLOAD_BYTES = 4,
  parameter logic [7:0]  HDR_A         = 8'hA5,
  parameter logic [7:0]  HDR_B         = 8'hC3
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       serial_data,
  input  logic       data_ena,
  input  logic       fifo_full,
  input  logic       clear_ovf,
  output logic       wr,
  output logic [7:0] wr_data,
  output logic       pkt_type,
  output logic       pkt_done,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned HUNT_W  = 4;
  localparam int unsigned BIT_W   = 3;
  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(PAYLOAD_BYTES - 1);
  localparam logic [HUNT_W-1:0] HUNT_MAX  = HUNT_W'(8);

  typedef enum logic {HUNT, PAYLOAD} state_t;

  state_t              state;
  // Only the 7 most recent bits are kept; the 8th is serial_data itself.
  logic [BYTE_W-2:0]   sr;
  logic [HUNT_W-1:0]   hunt_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [CNT_W-1:0]    byte_cnt;
  logic [BYTE_W-1:0]   window;

  assign window = {sr, serial_data};

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state    <= HUNT;
      sr       <= '0;
      hunt_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      wr       <= 1'b0;
      wr_data  <= '0;
      pkt_type <= 1'b0;
      pkt_done <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      wr       <= 1'b0;
      pkt_done <= 1'b0;
      if (clear_ovf) overflow <= 1'b0;

      if (data_ena) begin
        sr <= window[BYTE_W-2:0];
        case (state)
          HUNT: begin
            if (hunt_cnt != HUNT_MAX) hunt_cnt <= hunt_cnt + HUNT_W'(1);
            if ((hunt_cnt >= HUNT_W'(7)) && ((window == HDR_A) || (window == HDR_B))) begin
              pkt_type <= (window == HDR_B);
              state    <= PAYLOAD;
              bit_cnt  <= '0;
              byte_cnt <= '0;
              busy     <= 1'b1;
            end
          end
          PAYLOAD: begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            // Byte boundary: either commit the byte or abort on a full FIFO.
            if (bit_cnt == BIT_W'(7)) begin
              bit_cnt <= '0;
              if (fifo_full) begin
                overflow <= 1'b1;
                state    <= HUNT;
                hunt_cnt <= '0;
                busy     <= 1'b0;
              end else begin
                wr       <= 1'b1;
                wr_data  <= window;
                byte_cnt <= byte_cnt + CNT_W'(1);
                if (byte_cnt == LAST_BYTE) begin
                  pkt_done <= 1'b1;
                  state    <= HUNT;
                  hunt_cnt <= '0;
                  busy     <= 1'b0;
                end
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_pkt_ctrl.sv
// Directed bench for serial_pkt_ctrl: drives bytes bit-serially and checks
// captured FIFO writes, their timing and the status flags.
module tb_serial_pkt_ctrl;

  logic       clk_50 = 1'b0;
  logic       reset, serial_data, data_ena, fifo_full, clear_ovf;
  logic       wr, pkt_type, pkt_done, overflow, busy;
  logic [7:0] wr_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stray_done = 0;
  int consec_wr = 0;
  logic prev_wr = 1'b0;

  logic [7:0] wq_data[$];
  int         wq_cyc[$];
  logic       wq_done[$];
  logic       wq_type[$];

  serial_pkt_ctrl dut (
    .clk_50(clk_50), .reset(reset), .serial_data(serial_data), .data_ena(data_ena),
    .fifo_full(fifo_full), .clear_ovf(clear_ovf), .wr(wr), .wr_data(wr_data),
    .pkt_type(pkt_type), .pkt_done(pkt_done), .overflow(overflow), .busy(busy)
  );

  always #10 clk_50 = ~clk_50;

  always @(posedge clk_50) cyc <= cyc + 1;

  // Capture every write away from the active edge.
  always @(negedge clk_50) begin
    if (wr) begin
      wq_data.push_back(wr_data);
      wq_cyc.push_back(cyc);
      wq_done.push_back(pkt_done);
      wq_type.push_back(pkt_type);
    end
    if (pkt_done && !wr) stray_done++;
    if (wr && prev_wr) consec_wr++;
    prev_wr = wr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input logic ff, input logic alt);
    serial_data = b;
    data_ena    = 1'b1;
    fifo_full   = ff;
    @(negedge clk_50);
    if (alt) begin
      data_ena    = 1'b0;
      serial_data = ~b;
      fifo_full   = 1'b1;
      @(negedge clk_50);
    end
    data_ena  = 1'b0;
    fifo_full = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ff_last, input logic alt);
    for (int i = 7; i >= 0; i--) drive_bit(b[i], ff_last && (i == 0), alt);
  endtask

  task automatic idle(input int n);
    data_ena  = 1'b0;
    fifo_full = 1'b0;
    repeat (n) @(negedge clk_50);
  endtask

  // Compare captured writes against n expected bytes (first byte in bits 31:24).
  task automatic check_pkt(input string tag, input int n, input logic [31:0] bytes,
                           input logic exp_type, input logic last_done);
    check({tag, "_nwr"}, 32'(wq_data.size()), 32'(n));
    for (int i = 0; i < n && i < wq_data.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), 32'(wq_data[i]), 32'(bytes[31-8*i -: 8]));
      check($sformatf("%s_type%0d", tag, i), 32'(wq_type[i]), 32'(exp_type));
      check($sformatf("%s_done%0d", tag, i), 32'(wq_done[i]), 32'(last_done && (i == n - 1)));
    end
    wq_data.delete(); wq_cyc.delete(); wq_done.delete(); wq_type.delete();
  endtask

  int c0;

  initial begin
    reset = 1'b1; serial_data = 1'b0; data_ena = 1'b0; fifo_full = 1'b0; clear_ovf = 1'b0;
    repeat (3) @(negedge clk_50);
    check("rst_wr", 32'(wr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_pkt_done", 32'(pkt_done), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_type", 32'(pkt_type), 0);
    reset = 1'b0;
    @(negedge clk_50);

    // 1: basic A5 packet, continuous enable
    c0 = cyc;
    send_byte(8'hA5, 1'b0, 1'b0);
    check("t1_busy_hdr", 32'(busy), 1);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0);
    check("t1_busy_end", 32'(busy), 0);
    idle(2);
    if (wq_cyc.size() == 4) begin
      check("t1_lat", 32'(wq_cyc[0] - c0), 32'd16);
      for (int i = 1; i < 4; i++)
        check($sformatf("t1_gap%0d", i), 32'(wq_cyc[i] - wq_cyc[i-1]), 32'd8);
    end
    check_pkt("t1", 4, 32'h11223344, 1'b0, 1'b1);

    // 2: junk bits then C3 found by sliding window
    drive_bit(1'b1, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b0);
    check("t2_busy_hdr", 32'(busy), 1);
    send_byte(8'hDE, 1'b0, 1'b0);
    send_byte(8'hAD, 1'b0, 1'b0);
    send_byte(8'hBE, 1'b0, 1'b0);
    send_byte(8'hEF, 1'b0, 1'b0);
    idle(2);
    check_pkt("t2", 4, 32'hDEADBEEF, 1'b1, 1'b1);

    // 3: enable every other cycle, disabled bits toggled
    c0 = cyc;
    send_byte(8'hA5, 1'b0, 1'b1);
    send_byte(8'h11, 1'b0, 1'b1);
    send_byte(8'h22, 1'b0, 1'b1);
    send_byte(8'h33, 1'b0, 1'b1);
    send_byte(8'h44, 1'b0, 1'b1);
    idle(2);
    if (wq_cyc.size() == 4) begin
      check("t3_lat", 32'(wq_cyc[0] - c0), 32'd31);
      for (int i = 1; i < 4; i++)
        check($sformatf("t3_gap%0d", i), 32'(wq_cyc[i] - wq_cyc[i-1]), 32'd16);
    end
    check_pkt("t3", 4, 32'h11223344, 1'b0, 1'b1);

    // 4: FIFO-full abort on third payload byte
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h03, 1'b1, 1'b0);
    check("t4_ovf", 32'(overflow), 1);
    check("t4_busy", 32'(busy), 0);
    send_byte(8'h04, 1'b0, 1'b0);
    idle(2);
    check_pkt("t4a", 2, 32'h01020000, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h05, 1'b0, 1'b0);
    send_byte(8'h06, 1'b0, 1'b0);
    send_byte(8'h07, 1'b0, 1'b0);
    send_byte(8'h08, 1'b0, 1'b0);
    idle(2);
    check("t4_ovf_held", 32'(overflow), 1);
    check_pkt("t4b", 4, 32'h05060708, 1'b0, 1'b1);
    clear_ovf = 1'b1;
    @(negedge clk_50);
    clear_ovf = 1'b0;
    check("t4_ovf_clr", 32'(overflow), 0);
    // clear and abort in the same cycle: set wins
    send_byte(8'hA5, 1'b0, 1'b0);
    for (int i = 7; i >= 1; i--) drive_bit(1'(8'h09 >> i), 1'b0, 1'b0);
    serial_data = 1'b1; data_ena = 1'b1; fifo_full = 1'b1; clear_ovf = 1'b1;
    @(negedge clk_50);
    clear_ovf = 1'b0;
    idle(2);
    check("t4_ovf_setwins", 32'(overflow), 1);
    check_pkt("t4c", 0, 32'h0, 1'b0, 1'b0);
    clear_ovf = 1'b1;
    @(negedge clk_50);
    clear_ovf = 1'b0;
    check("t4_ovf_clr2", 32'(overflow), 0);

    // 5: header values inside payload are data
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    idle(2);
    check_pkt("t5a", 4, 32'hA5C3A500, 1'b0, 1'b1);
    // payload ends in 1; 7 more bits would form C3 with it, but must not match
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    for (int i = 6; i >= 0; i--) drive_bit(1'(8'hC3 >> i), 1'b0, 1'b0);
    idle(2);
    check("t5_no_overlap", 32'(busy), 0);
    check_pkt("t5b", 4, 32'h00000001, 1'b0, 1'b1);
    send_byte(8'hC3, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0);
    idle(2);
    check_pkt("t5c", 4, 32'h11223344, 1'b1, 1'b1);

    // 6: reset mid-packet discards the rest
    send_byte(8'hC3, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk_50);
    reset = 1'b0;
    check("t6_wr", 32'(wr), 0);
    check("t6_wr_data", 32'(wr_data), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_type", 32'(pkt_type), 0);
    check("t6_done", 32'(pkt_done), 0);
    idle(2);
    check_pkt("t6a", 2, 32'h01020000, 1'b1, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0);
    idle(2);
    check_pkt("t6b", 0, 32'h0, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0);
    idle(2);
    check_pkt("t6c", 4, 32'h11223344, 1'b0, 1'b1);

    check("stray_done", 32'(stray_done), 0);
    check("consec_wr", 32'(consec_wr), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
